// File: rtl/n64_bus_arbiter_pkg.sv
// Shared definitions for the N64 memory bus arbiter: field widths, FSM states,
// master indices and the latched downstream command.
package n64_bus_arbiter_pkg;

  localparam int BANK_W = 4;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam int MST_PI  = 0;
  localparam int MST_CPU = 1;
  localparam int MST_DMA = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              write;
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } mem_cmd_t;

endpackage

// File: rtl/n64_bus_arbiter_rr_select.sv
// Combinational round-robin pick: first requester searching upward from
// last_grant+1 with wrap-around; o_valid low when nobody requests.
module n64_rr_select #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_request,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (!o_valid && i_request[w_cand]) begin
        o_valid = 1'b1;
        o_grant = w_cand;
      end
    end
  end

endmodule

// File: rtl/n64_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ masters; one
// transaction in flight, grant +1 cycle, ack +1 cycle, ack timeout recovers a lost ack.
module n64_bus_arbiter
  import n64_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_request,
  input  logic [NUM_REQ-1:0]        i_write,
  input  logic [BANK_W*NUM_REQ-1:0] i_bank,
  input  logic [ADDR_W*NUM_REQ-1:0] i_address,
  input  logic [DATA_W*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_busy,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_timeout,
  output logic                      o_mem_request,
  output logic                      o_mem_write,
  output logic [BANK_W-1:0]         o_mem_bank,
  output logic [ADDR_W-1:0]         o_mem_address,
  output logic [DATA_W-1:0]         o_mem_data,
  input  logic                      i_mem_busy,
  input  logic                      i_mem_ack,
  input  logic [DATA_W-1:0]         i_mem_data
);

  localparam int              IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(ACK_TIMEOUT);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_last_grant;
  mem_cmd_t            r_cmd;
  logic                r_mem_request;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_data;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_ack_cnt;

  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_sel_vld;
  mem_cmd_t            w_sel_cmd;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [NUM_REQ-1:0]  w_busy;

  n64_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .i_request    (i_request),
    .i_last_grant (r_last_grant),
    .o_grant      (w_sel_idx),
    .o_valid      (w_sel_vld)
  );

  always_comb begin
    w_sel_cmd         = '0;
    w_sel_cmd.write   = i_write[w_sel_idx];
    w_sel_cmd.bank    = i_bank[int'(w_sel_idx)*BANK_W +: BANK_W];
    w_sel_cmd.address = i_address[int'(w_sel_idx)*ADDR_W +: ADDR_W];
    w_sel_cmd.data    = i_data[int'(w_sel_idx)*DATA_W +: DATA_W];
  end

  // Saturating so a huge ACK_TIMEOUT can never wrap back to a small count.
  assign w_cnt_next = (r_ack_cnt == '1) ? r_ack_cnt : r_ack_cnt + 1'b1;

  // Only the owner sees the downstream accept; everyone else stays stalled.
  always_comb begin
    w_busy = '1;
    if (r_state == ST_ISSUE) begin
      w_busy[r_grant] = i_mem_busy;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_last_grant  <= IDX_W'(NUM_REQ - 1);
      r_cmd         <= '0;
      r_mem_request <= 1'b0;
      r_ack         <= '0;
      r_data        <= '0;
      r_timeout     <= 1'b0;
      r_ack_cnt     <= '0;
    end else begin
      r_ack     <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_vld) begin
            r_grant       <= w_sel_idx;
            r_last_grant  <= w_sel_idx;
            r_cmd         <= w_sel_cmd;
            r_mem_request <= 1'b1;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!i_mem_busy) begin
            r_mem_request <= 1'b0;
            r_cmd.write   <= 1'b0;
            r_ack_cnt     <= '0;
            if (i_mem_ack) begin
              r_ack[r_grant] <= 1'b1;
              r_data         <= i_mem_data;
              r_state        <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT_ACK;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (i_mem_ack) begin
            r_ack[r_grant] <= 1'b1;
            r_data         <= i_mem_data;
            r_state        <= ST_IDLE;
          end else if (w_cnt_next >= TMO_LIMIT) begin
            // Complete with zero data so the owner is never left waiting.
            r_timeout      <= 1'b1;
            r_ack[r_grant] <= 1'b1;
            r_data         <= '0;
            r_state        <= ST_IDLE;
          end else begin
            r_ack_cnt <= w_cnt_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = w_busy;
  assign o_ack         = r_ack;
  assign o_data        = r_data;
  assign o_timeout     = r_timeout;
  assign o_mem_request = r_mem_request;
  assign o_mem_write   = r_cmd.write;
  assign o_mem_bank    = r_cmd.bank;
  assign o_mem_address = r_cmd.address;
  assign o_mem_data    = r_cmd.data;

endmodule

// File: doc/n64_bus_arbiter.md
# n64_bus_arbiter

Shares one downstream memory bus port (SDRAM/bank controller) between several bus masters: the N64 PI front end, the CPU and the USB/SD DMA. Each master uses the same request/busy/ack handshake the PI front end already drives. The arbiter grants masters round-robin and latches the winning command. It sequences exactly one outstanding transaction at a time and routes the completion ack and read data back to the owner. An ack timeout guarantees that a missing ack never deadlocks the bus.

## Interface
Parameters:
- NUM_REQ, 3, number of masters; index 0 = PI, 1 = CPU, 2 = DMA.
- ACK_TIMEOUT, 1023, maximum cycles spent in WAIT_ACK; legal range 1..65535.

Ports:
- i_clk  in  1  system clock; one clock domain.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_request  in  NUM_REQ  per-master request; held high until the master samples its o_busy low.
- i_write  in  NUM_REQ  per-master write flag.
- i_bank  in  4*NUM_REQ  per-master bank, packed with master k at [4k+3:4k].
- i_address  in  26*NUM_REQ  per-master address, packed the same way.
- i_data  in  32*NUM_REQ  per-master write data, packed the same way.
- o_busy  out  NUM_REQ  per-master busy; low for one cycle = command accepted.
- o_ack  out  NUM_REQ  per-master one-cycle completion pulse.
- o_data  out  32  read data; valid with any o_ack bit.
- o_timeout  out  1  one-cycle pulse when an ack timeout fires.
- o_mem_request, o_mem_write  out  1 each  downstream command.
- o_mem_bank  out  4  downstream bank.
- o_mem_address  out  26  downstream address.
- o_mem_data  out  32  downstream write data.
- i_mem_busy  in  1  downstream busy.
- i_mem_ack  in  1  downstream completion pulse.
- i_mem_data  in  32  downstream read data.

## Operation
- States: IDLE, ISSUE, WAIT_ACK.
- IDLE, when any i_request bit is high:
  - Select the first requesting index, searching upward (with wrap-around) from last_grant+1.
  - Register grant and last_grant <= grant.
  - Latch that master's write/bank/address/data into the o_mem_* registers.
  - Set o_mem_request = 1 and go to ISSUE.
- ISSUE: o_busy[grant] = i_mem_busy (combinational). All other o_busy bits stay 1.
- ISSUE, when !i_mem_busy (accept): clear o_mem_request and o_mem_write, load the timeout counter with 0, and go to WAIT_ACK.
  - If i_mem_ack is also high in the accept cycle, complete immediately instead: register the ack and go to IDLE.
- WAIT_ACK: on i_mem_ack, register o_ack[grant] = 1 and o_data = i_mem_data (read data is also forwarded on writes), then go to IDLE.
- WAIT_ACK timeout: if the counter reaches ACK_TIMEOUT without an ack, pulse o_timeout, also pulse o_ack[grant] with o_data = 32'h0000_0000, and go to IDLE.
- A fixed 0, 1, 0, 1 toggling i_mem_ack pattern outside WAIT_ACK/accept is a protocol violation: such acks are ignored and produce no o_ack.
- A master dropping i_request while in ISSUE is illegal. The latched command still completes and is still acked.
- Counter width is 16 bits. It saturates and never wraps.

## Timing
- Reset (asynchronous, active-low) values:
  - State = IDLE, last_grant = NUM_REQ-1 (master 0 wins first).
  - o_busy = all 1s, o_ack = 0, o_data = 0, o_timeout = 0.
  - o_mem_request = 0, o_mem_write = 0, o_mem_bank = 0, o_mem_address = 0, o_mem_data = 0.
- Reset mid-transaction aborts the transaction with no ack; the downstream controller is reset by the same net.
- Grant latency: i_request high while IDLE in cycle N -> o_mem_request high in cycle N+1.
- Accept: o_busy[grant] low in the same cycle that i_mem_busy is low during ISSUE.
- Ack latency: i_mem_ack in cycle M -> o_ack/o_data in cycle M+1, state IDLE in cycle M+1, next o_mem_request no earlier than cycle M+2.
- Back-to-back grant: a new request can be granted in the IDLE cycle M+1.
- o_mem_* outputs are registered and stable for the whole of ISSUE.

## Structure
- Shared bus package holds: the bank width (4), address width (26), data width (32), the arbiter state enum, and the master index constants (PI = 0, CPU = 1, DMA = 2).
- One sub-module: n64_rr_select. It is combinational; inputs are the request vector and last_grant, outputs are the grant index and a valid flag. It is reused by other arbiters.

## Test plan
- Single read: after reset, master 1 requests a read at address 26'h0000100. i_mem_busy is low and i_mem_ack comes 5 cycles after accept with data 32'hDEADBEEF -> o_busy[1] is low 1 cycle after the request, o_ack[1] pulses once, o_data = 32'hDEADBEEF, no other o_ack bit is set.
- Round-robin: all three masters request continuously with immediate acks -> grant order 0, 1, 2, 0, 1, 2.
- Held busy: i_mem_busy held high for 10 cycles in ISSUE -> o_mem_request and o_mem_address stay stable and o_busy[grant] stays high, then accept happens on the first low cycle.
- Same-cycle accept and ack: i_mem_busy low and i_mem_ack high together -> o_ack arrives in the next cycle and the arbiter never enters WAIT_ACK.
- Timeout: ACK_TIMEOUT = 8 with no ack -> o_timeout and o_ack[grant] pulse together, o_data = 0, and the next pending request is granted in the following cycle.
- Reset mid-operation: i_reset_n goes low during WAIT_ACK -> all outputs go to their reset values immediately, and the first grant after release goes to master 0.
